// File: rtl/rs_multiway_pkg.sv
// Shared types and defaults for the multi-way reservation station.
package rs_multiway_pkg;

  localparam int RS_DEPTH_DEF  = 16;
  localparam int DP_WIDTH_DEF  = 3;
  localparam int IS_WIDTH_DEF  = 3;
  localparam int CDB_WIDTH_DEF = 3;
  localparam int TAG_W_DEF     = 6;
  localparam int ROB_W_DEF     = 5;
  localparam int XLEN_DEF      = 32;
  localparam int PAY_W_DEF     = 64;

  // One source operand: producer tag, value-valid flag, captured value.
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic                 rdy;
    logic [XLEN_DEF-1:0]  val;
  } rs_src_t;

  // One reservation-station slot at the default widths.
  typedef struct packed {
    logic                 busy;
    logic [ROB_W_DEF-1:0] rob;
    logic [TAG_W_DEF-1:0] dest;
    rs_src_t              src1;
    rs_src_t              src2;
    logic [PAY_W_DEF-1:0] payload;
  } rs_entry_t;

  // Registered issue packet at the default widths.
  typedef struct packed {
    logic [ROB_W_DEF-1:0] rob;
    logic [TAG_W_DEF-1:0] dest;
    logic [XLEN_DEF-1:0]  src1_val;
    logic [XLEN_DEF-1:0]  src2_val;
    logic [PAY_W_DEF-1:0] payload;
  } issue_pkt_t;

  // Value driven on an idle issue lane.
  localparam issue_pkt_t ISSUE_NOP = '0;

endpackage

// File: rtl/rs_multiway_if.sv
// Dispatch, CDB and issue bundle between the core and the reservation station.
interface rs_multiway_if
  import rs_multiway_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int DP_WIDTH  = DP_WIDTH_DEF,
  parameter int IS_WIDTH  = IS_WIDTH_DEF,
  parameter int CDB_WIDTH = CDB_WIDTH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int PAY_W     = PAY_W_DEF
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  logic                               squash;

  logic [DP_WIDTH-1:0]                dp_valid;
  logic [DP_WIDTH-1:0][ROB_W-1:0]     dp_rob;
  logic [DP_WIDTH-1:0][TAG_W-1:0]     dp_dest;
  logic [DP_WIDTH-1:0][TAG_W-1:0]     dp_src1_tag;
  logic [DP_WIDTH-1:0][TAG_W-1:0]     dp_src2_tag;
  logic [DP_WIDTH-1:0]                dp_src1_rdy;
  logic [DP_WIDTH-1:0]                dp_src2_rdy;
  logic [DP_WIDTH-1:0][XLEN-1:0]      dp_src1_val;
  logic [DP_WIDTH-1:0][XLEN-1:0]      dp_src2_val;
  logic [DP_WIDTH-1:0][PAY_W-1:0]     dp_payload;
  logic [CNT_W-1:0]                   free_count;
  logic                               dp_overflow;

  logic [CDB_WIDTH-1:0]               cdb_valid;
  logic [CDB_WIDTH-1:0][TAG_W-1:0]    cdb_tag;
  logic [CDB_WIDTH-1:0][XLEN-1:0]     cdb_val;

  logic [IS_WIDTH-1:0]                is_en;
  logic [IS_WIDTH-1:0]                is_valid;
  logic [IS_WIDTH-1:0][ROB_W-1:0]     is_rob;
  logic [IS_WIDTH-1:0][TAG_W-1:0]     is_dest;
  logic [IS_WIDTH-1:0][XLEN-1:0]      is_src1_val;
  logic [IS_WIDTH-1:0][XLEN-1:0]      is_src2_val;
  logic [IS_WIDTH-1:0][PAY_W-1:0]     is_payload;

  // Core side: dispatches, broadcasts, enables issue lanes.
  modport master (
    output squash, dp_valid, dp_rob, dp_dest, dp_src1_tag, dp_src2_tag,
           dp_src1_rdy, dp_src2_rdy, dp_src1_val, dp_src2_val, dp_payload,
           cdb_valid, cdb_tag, cdb_val, is_en,
    input  free_count, dp_overflow, is_valid, is_rob, is_dest,
           is_src1_val, is_src2_val, is_payload
  );

  // Reservation-station side.
  modport slave (
    input  squash, dp_valid, dp_rob, dp_dest, dp_src1_tag, dp_src2_tag,
           dp_src1_rdy, dp_src2_rdy, dp_src1_val, dp_src2_val, dp_payload,
           cdb_valid, cdb_tag, cdb_val, is_en,
    output free_count, dp_overflow, is_valid, is_rob, is_dest,
           is_src1_val, is_src2_val, is_payload
  );

endinterface

// File: rtl/rs_multiway_psel_multi.sv
// Iterated lowest-index priority selector: grant g is the g-th lowest set
// request bit, one-hot, or all zero when fewer than g+1 requests exist.
module psel_multi
  import rs_multiway_pkg::*;
#(
  parameter int WIDTH = RS_DEPTH_DEF,
  parameter int NGNT  = 2
) (
  input  logic [WIDTH-1:0]           req,
  output logic [NGNT-1:0][WIDTH-1:0] gnt
);

  // Peel off the lowest remaining request once per grant.
  always_comb begin : select
    logic [WIDTH-1:0] rem;
    logic             found;
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    rem   = req;
    found = 1'b0;
    gnt   = '0;
    for (int g = 0; g < NGNT; g++) begin
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (rem[i] && !found) begin
          gnt[g][i] = 1'b1;
          found     = 1'b1;
        end
      end
      rem = rem & ~gnt[g];
    end
  end

endmodule

// File: rtl/rs_multiway.sv
// Multi-way reservation station: DP_WIDTH dispatch lanes, CDB_WIDTH wakeup
// lanes with dispatch bypass, IS_WIDTH registered issue lanes, full squash.
// Entry and packet types mirror the package layout at the configured widths.
module rs_multiway
  import rs_multiway_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int DP_WIDTH  = DP_WIDTH_DEF,
  parameter int IS_WIDTH  = IS_WIDTH_DEF,
  parameter int CDB_WIDTH = CDB_WIDTH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int PAY_W     = PAY_W_DEF
) (
  input logic          clock,
  input logic          reset,
  rs_multiway_if.slave bus
);

  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [XLEN-1:0]  val;
  } src_t;

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    src_t             src1;
    src_t             src2;
    logic [PAY_W-1:0] payload;
  } entry_t;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    logic [XLEN-1:0]  src1_val;
    logic [XLEN-1:0]  src2_val;
    logic [PAY_W-1:0] payload;
  } pkt_t;

  entry_t                             ent_q [RS_DEPTH];
  entry_t                             ent_d [RS_DEPTH];
  pkt_t                               pkt_q [IS_WIDTH];
  pkt_t                               pkt_d [IS_WIDTH];
  logic [IS_WIDTH-1:0]                is_valid_q, is_valid_d;
  logic                               overflow_q, overflow_d;
  logic [RS_DEPTH-1:0]                free_vec, ready_vec;
  logic [DP_WIDTH-1:0][RS_DEPTH-1:0]  alloc_gnt;
  logic [IS_WIDTH-1:0][RS_DEPTH-1:0]  iss_gnt;

  // Capture a CDB value into a waiting source; lowest matching lane wins.
  function automatic src_t wake_src(
    input src_t                            s,
    input logic [CDB_WIDTH-1:0]            v,
    input logic [CDB_WIDTH-1:0][TAG_W-1:0] t,
    input logic [CDB_WIDTH-1:0][XLEN-1:0]  d
  );
    src_t r;
    logic hit;
    r   = s;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      if (!s.rdy && !hit && v[c] && (t[c] == s.tag)) begin
        r.rdy = 1'b1;
        r.val = d[c];
        hit   = 1'b1;
      end
    end
    return r;
  endfunction

  // Free and ready masks come from registered state only.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i]  = !ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
    end
  end

  psel_multi #(.WIDTH(RS_DEPTH), .NGNT(DP_WIDTH)) u_alloc_sel (
    .req (free_vec),
    .gnt (alloc_gnt)
  );

  psel_multi #(.WIDTH(RS_DEPTH), .NGNT(IS_WIDTH)) u_issue_sel (
    .req (ready_vec),
    .gnt (iss_gnt)
  );

  // Next entry array and issue packets: issue, wakeup, dispatch, then squash.
  always_comb begin : next_state
    int                  en_cnt;
    int                  dp_cnt;
    logic [RS_DEPTH-1:0] lane_gnt;
    logic [RS_DEPTH-1:0] slot;
    entry_t              new_e;
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results; registers use '<='.
    ent_d      = ent_q;
    is_valid_d = '0;
    for (int l = 0; l < IS_WIDTH; l++) pkt_d[l] = '0;
    overflow_d = 1'b0;
    en_cnt     = 0;
    dp_cnt     = 0;
    lane_gnt   = '0;
    slot       = '0;
    new_e      = '0;

    // Enabled lanes take successive grants; a disabled lane skips none.
    for (int l = 0; l < IS_WIDTH; l++) begin
      lane_gnt = '0;
      if (bus.is_en[l]) begin
        for (int k = 0; k < IS_WIDTH; k++) begin
          if (k == en_cnt) lane_gnt = iss_gnt[k];
        end
        en_cnt++;
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (lane_gnt[i]) begin
          is_valid_d[l]        = 1'b1;
          pkt_d[l].rob         = ent_q[i].rob;
          pkt_d[l].dest        = ent_q[i].dest;
          pkt_d[l].src1_val    = ent_q[i].src1.val;
          pkt_d[l].src2_val    = ent_q[i].src2.val;
          pkt_d[l].payload     = ent_q[i].payload;
          ent_d[i].busy        = 1'b0;
        end
      end
    end

    // Wake waiting sources of resident entries.
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].src1 = wake_src(ent_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        ent_d[i].src2 = wake_src(ent_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      end
    end

    // The k-th valid lane lands in the k-th lowest free slot, or is dropped.
    for (int d = 0; d < DP_WIDTH; d++) begin
      if (bus.dp_valid[d]) begin
        slot = '0;
        for (int k = 0; k < DP_WIDTH; k++) begin
          if (k == dp_cnt) slot = alloc_gnt[k];
        end
        dp_cnt++;
        new_e.busy      = 1'b1;
        new_e.rob       = bus.dp_rob[d];
        new_e.dest      = bus.dp_dest[d];
        new_e.src1.tag  = bus.dp_src1_tag[d];
        new_e.src1.rdy  = bus.dp_src1_rdy[d];
        new_e.src1.val  = bus.dp_src1_val[d];
        new_e.src2.tag  = bus.dp_src2_tag[d];
        new_e.src2.rdy  = bus.dp_src2_rdy[d];
        new_e.src2.val  = bus.dp_src2_val[d];
        new_e.payload   = bus.dp_payload[d];
        new_e.src1      = wake_src(new_e.src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        new_e.src2      = wake_src(new_e.src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        if (slot == '0) overflow_d = 1'b1;
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (slot[i]) ent_d[i] = new_e;
        end
      end
    end

    // Squash overrides everything decided above.
    if (bus.squash) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
      is_valid_d = '0;
      for (int l = 0; l < IS_WIDTH; l++) pkt_d[l] = '0;
      overflow_d = 1'b0;
    end
  end

  // Entry array, issue registers and overflow pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: only the busy bits are reset; entry data is never read while busy is clear.
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i].busy <= 1'b0;
      for (int l = 0; l < IS_WIDTH; l++) pkt_q[l] <= '0;
      is_valid_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      pkt_q      <= pkt_d;
      is_valid_q <= is_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Free-entry count straight from the registered busy bits.
  always_comb begin
    bus.free_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (free_vec[i]) bus.free_count = bus.free_count + CNT_W'(1);
    end
  end

  // Drive the registered issue packets and overflow pulse.
  always_comb begin
    bus.is_valid    = is_valid_q;
    bus.dp_overflow = overflow_q;
    for (int l = 0; l < IS_WIDTH; l++) begin
      bus.is_rob[l]      = pkt_q[l].rob;
      bus.is_dest[l]     = pkt_q[l].dest;
      bus.is_src1_val[l] = pkt_q[l].src1_val;
      bus.is_src2_val[l] = pkt_q[l].src2_val;
      bus.is_payload[l]  = pkt_q[l].payload;
    end
  end

endmodule

// File: tb/tb_rs_multiway.sv
// Self-checking bench for rs_multiway: wakeup vector table plus hand-written
// sequences for throughput, overflow, lane masking and squash.
module tb_rs_multiway;
  import rs_multiway_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [4:0] next_rob = '0;
  issue_pkt_t sb [$];

  always #5 clock = ~clock;

  rs_multiway_if bus ();

  rs_multiway dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string            name;
    logic [5:0]       t1;
    logic             r1;
    logic [31:0]      v1;
    logic [5:0]       t2;
    logic             r2;
    logic [31:0]      v2;
    logic [2:0]       cv0;
    logic [2:0][5:0]  ct0;
    logic [2:0][31:0] cd0;
    logic [2:0]       cv1;
    logic [2:0][5:0]  ct1;
    logic [2:0][31:0] cd1;
    int               lat;
    logic [31:0]      e1;
    logic [31:0]      e2;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.squash      = 1'b0;
    bus.dp_valid    = '0;
    bus.dp_rob      = '0;
    bus.dp_dest     = '0;
    bus.dp_src1_tag = '0;
    bus.dp_src2_tag = '0;
    bus.dp_src1_rdy = '0;
    bus.dp_src2_rdy = '0;
    bus.dp_src1_val = '0;
    bus.dp_src2_val = '0;
    bus.dp_payload  = '0;
    bus.cdb_valid   = '0;
    bus.cdb_tag     = '0;
    bus.cdb_val     = '0;
  endtask

  // Drive one dispatch lane; optionally record the packet it must issue as.
  task automatic set_dp(input int l, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                        input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                        input bit push, input logic [31:0] e1, input logic [31:0] e2);
    issue_pkt_t p;
    p.rob      = next_rob;
    p.dest     = {1'b1, next_rob};
    p.src1_val = e1;
    p.src2_val = e2;
    p.payload  = {8{3'b101, next_rob}};
    bus.dp_valid[l]    = 1'b1;
    bus.dp_rob[l]      = p.rob;
    bus.dp_dest[l]     = p.dest;
    bus.dp_src1_tag[l] = t1;
    bus.dp_src1_rdy[l] = r1;
    bus.dp_src1_val[l] = v1;
    bus.dp_src2_tag[l] = t2;
    bus.dp_src2_rdy[l] = r2;
    bus.dp_src2_val[l] = v2;
    bus.dp_payload[l]  = p.payload;
    if (push) sb.push_back(p);
    next_rob = next_rob + 5'd1;
  endtask

  // Advance one edge, then compare every issued lane against the scoreboard.
  task automatic step();
    issue_pkt_t e;
    @(posedge clock);
    #1;
    for (int l = 0; l < 3; l++) begin
      if (bus.is_valid[l] === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected: lane %0d issued rob %0d, expected no issue", l, bus.is_rob[l]);
        end else begin
          e = sb.pop_front();
          check($sformatf("issue_lane%0d", l),
                256'({bus.is_rob[l], bus.is_dest[l], bus.is_src1_val[l], bus.is_src2_val[l], bus.is_payload[l]}),
                256'(e));
        end
      end
    end
  endtask

  function automatic vec_t mkv(input string n,
      input logic [5:0] t1, input logic r1, input logic [31:0] v1,
      input logic [5:0] t2, input logic r2, input logic [31:0] v2,
      input logic [2:0] cv0, input logic [2:0][5:0] ct0, input logic [2:0][31:0] cd0,
      input logic [2:0] cv1, input logic [2:0][5:0] ct1, input logic [2:0][31:0] cd1,
      input int lat, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.name = n; v.t1 = t1; v.r1 = r1; v.v1 = v1; v.t2 = t2; v.r2 = r2; v.v2 = v2;
    v.cv0 = cv0; v.ct0 = ct0; v.cd0 = cd0; v.cv1 = cv1; v.ct1 = ct1; v.cd1 = cd1;
    v.lat = lat; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // CDB lanes are listed {lane2, lane1, lane0}; lat 0 = must not issue unaided.
    vecs.push_back(mkv("both_ready", 6'd1, 1, 32'h11, 6'd2, 1, 32'h22,
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0},
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0}, 1, 32'h11, 32'h22));
    vecs.push_back(mkv("wake_next_cycle", 6'd5, 0, 32'h0, 6'd2, 1, 32'h22,
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0},
      3'b001, {6'd0, 6'd0, 6'd5}, {32'h0, 32'h0, 32'hDEAD}, 2, 32'hDEAD, 32'h22));
    vecs.push_back(mkv("bypass_src2", 6'd1, 1, 32'h33, 6'd9, 0, 32'h0,
      3'b001, {6'd0, 6'd0, 6'd9}, {32'h0, 32'h0, 32'h42},
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0}, 1, 32'h33, 32'h42));
    vecs.push_back(mkv("wake_lowest_lane", 6'd7, 0, 32'h0, 6'd2, 1, 32'h44,
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0},
      3'b111, {6'd7, 6'd7, 6'd8}, {32'hB2, 32'hB1, 32'hB0}, 2, 32'hB1, 32'h44));
    vecs.push_back(mkv("bypass_lowest_valid_lane", 6'd3, 0, 32'h0, 6'd3, 0, 32'h0,
      3'b110, {6'd3, 6'd3, 6'd3}, {32'hA2, 32'hA1, 32'hA0},
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0}, 1, 32'hA1, 32'hA1));
    vecs.push_back(mkv("ready_src_ignores_cdb", 6'd5, 1, 32'h55, 6'd6, 1, 32'h66,
      3'b011, {6'd0, 6'd6, 6'd5}, {32'h0, 32'h99, 32'h98},
      3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0}, 1, 32'h55, 32'h66));
    vecs.push_back(mkv("invalid_cdb_no_wake", 6'd12, 0, 32'h0, 6'd2, 1, 32'h77,
      3'b000, {6'd12, 6'd12, 6'd12}, {32'h1, 32'h2, 32'h3},
      3'b000, {6'd12, 6'd12, 6'd12}, {32'h4, 32'h5, 32'h6}, 0, 32'h1200, 32'h77));
    vecs.push_back(mkv("split_wake", 6'd20, 0, 32'h0, 6'd21, 0, 32'h0,
      3'b010, {6'd0, 6'd21, 6'd0}, {32'h0, 32'h21, 32'h0},
      3'b100, {6'd20, 6'd0, 6'd0}, {32'h20, 32'h0, 32'h0}, 2, 32'h20, 32'h21));

    // Reset state.
    clear_inputs();
    bus.is_en = 3'b111;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_free_count", 256'(bus.free_count), 256'(16));
    check("reset_is_valid", 256'(bus.is_valid), 256'(0));
    check("reset_overflow", 256'(bus.dp_overflow), 256'(0));
    for (int l = 0; l < 3; l++)
      check($sformatf("reset_packet%0d", l),
            256'({bus.is_rob[l], bus.is_dest[l], bus.is_src1_val[l], bus.is_src2_val[l], bus.is_payload[l]}),
            256'(ISSUE_NOP));

    // Three ready ops: one cycle of residency, then all three lanes at once.
    for (int l = 0; l < 3; l++) set_dp(l, 6'd1, 1, 32'h100 + l, 6'd2, 1, 32'h200 + l, 1, 32'h100 + l, 32'h200 + l);
    step();
    check("tp3_resid_is_valid", 256'(bus.is_valid), 256'(0));
    check("tp3_free_after_dispatch", 256'(bus.free_count), 256'(13));
    clear_inputs();
    step();
    check("tp3_is_valid", 256'(bus.is_valid), 256'(3'b111));
    check("tp3_free_after_issue", 256'(bus.free_count), 256'(16));

    // Wakeup / bypass vector table, dispatched on lane 0.
    foreach (vecs[i]) begin
      clear_inputs();
      set_dp(0, vecs[i].t1, vecs[i].r1, vecs[i].v1, vecs[i].t2, vecs[i].r2, vecs[i].v2, 1, vecs[i].e1, vecs[i].e2);
      bus.cdb_valid = vecs[i].cv0;
      bus.cdb_tag   = vecs[i].ct0;
      bus.cdb_val   = vecs[i].cd0;
      step();
      check({vecs[i].name, "_resid"}, 256'(bus.is_valid), 256'(0));
      lat = 0;
      for (int c = 1; c <= 3; c++) begin
        clear_inputs();
        if (c == 1) begin
          bus.cdb_valid = vecs[i].cv1;
          bus.cdb_tag   = vecs[i].ct1;
          bus.cdb_val   = vecs[i].cd1;
        end
        step();
        if (bus.is_valid[0] === 1'b1 && lat == 0) lat = c;
      end
      check({vecs[i].name, "_latency"}, 256'(lat), 256'(vecs[i].lat));
      if (vecs[i].lat == 0) begin
        clear_inputs();
        bus.cdb_valid[0] = 1'b1;
        bus.cdb_tag[0]   = vecs[i].t1;
        bus.cdb_val[0]   = vecs[i].e1;
        step();
        clear_inputs();
        step();
      end
      check({vecs[i].name, "_drained"}, 256'(bus.free_count), 256'(16));
    end

    // Fill to one free slot with ops waiting on tag 40, then overflow.
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 3; l++) set_dp(l, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 1, 32'h40, 32'h2);
      step();
      clear_inputs();
    end
    check("fill_free_one", 256'(bus.free_count), 256'(1));
    set_dp(0, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 1, 32'h40, 32'h2);
    set_dp(1, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 0, 32'h0, 32'h0);
    set_dp(2, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 0, 32'h0, 32'h0);
    step();
    check("ovf_pulse", 256'(bus.dp_overflow), 256'(1));
    check("ovf_free_zero", 256'(bus.free_count), 256'(0));
    clear_inputs();
    step();
    check("ovf_pulse_ends", 256'(bus.dp_overflow), 256'(0));
    set_dp(0, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 0, 32'h0, 32'h0);
    set_dp(2, 6'd40, 0, 32'h0, 6'd2, 1, 32'h2, 0, 32'h0, 32'h0);
    step();
    check("full_drop_overflow", 256'(bus.dp_overflow), 256'(1));
    check("full_free_zero", 256'(bus.free_count), 256'(0));
    clear_inputs();
    bus.cdb_valid[0] = 1'b1;
    bus.cdb_tag[0]   = 6'd40;
    bus.cdb_val[0]   = 32'h40;
    step();
    check("full_wake_no_same_cycle_issue", 256'(bus.is_valid), 256'(0));
    clear_inputs();
    step();
    check("full_drain_first", 256'(bus.is_valid), 256'(3'b111));
    for (int c = 0; c < 6; c++) step();
    check("full_drained", 256'(bus.free_count), 256'(16));

    // Five ready entries held, then issue with lane 1 disabled.
    clear_inputs();
    bus.is_en = 3'b000;
    for (int l = 0; l < 3; l++) set_dp(l, 6'd1, 1, 32'h300 + l, 6'd2, 1, 32'h400 + l, 1, 32'h300 + l, 32'h400 + l);
    step();
    clear_inputs();
    for (int l = 0; l < 2; l++) set_dp(l, 6'd1, 1, 32'h310 + l, 6'd2, 1, 32'h410 + l, 1, 32'h310 + l, 32'h410 + l);
    step();
    clear_inputs();
    step();
    check("mask_held", 256'(bus.is_valid), 256'(0));
    check("mask_five_busy", 256'(bus.free_count), 256'(11));
    bus.is_en = 3'b101;
    step();
    check("mask_is_valid", 256'(bus.is_valid), 256'(3'b101));
    check("mask_three_left", 256'(bus.free_count), 256'(13));
    bus.is_en = 3'b111;
    step();
    check("mask_rest", 256'(bus.is_valid), 256'(3'b111));
    check("mask_drained", 256'(bus.free_count), 256'(16));

    // Squash with dispatch and CDB while eight entries are busy.
    bus.is_en = 3'b000;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 3; l++) if (c < 2 || l < 2) set_dp(l, 6'd50, 0, 32'h0, 6'd2, 1, 32'h2, 0, 32'h0, 32'h0);
      step();
      clear_inputs();
    end
    check("sq_eight_busy", 256'(bus.free_count), 256'(8));
    bus.is_en  = 3'b111;
    bus.squash = 1'b1;
    for (int l = 0; l < 3; l++) set_dp(l, 6'd1, 1, 32'h5, 6'd2, 1, 32'h6, 0, 32'h0, 32'h0);
    bus.cdb_valid[0] = 1'b1;
    bus.cdb_tag[0]   = 6'd50;
    bus.cdb_val[0]   = 32'h50;
    step();
    check("sq_free_count", 256'(bus.free_count), 256'(16));
    check("sq_is_valid", 256'(bus.is_valid), 256'(0));
    check("sq_overflow", 256'(bus.dp_overflow), 256'(0));
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("sq_quiet%0d", c), 256'(bus.is_valid), 256'(0));
    end

    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
